// File: rtl/cronometro_ctrl.sv
// Stopwatch sequencer: run/pause/done FSM, tick prescaler and edge-detected
// start/stop driving a bounded up/down counter. Optional lap hold via LAP_EN.
module cronometro_ctrl #(
  parameter int NBITS_COUNT = 4,
  parameter int MAX_COUNT   = 10,
  parameter int TICK_DIV    = 1
) (
  input  logic                   clk_2_i,
  input  logic                   reset_i,
  input  logic                   start_stop_i,
  input  logic                   clear_i,
  input  logic                   down_i,
  input  logic                   lap_i,
  output logic [NBITS_COUNT-1:0] count_o,
  output logic [NBITS_COUNT-1:0] display_o,
  output logic [1:0]             state_o,
  output logic                   running_o,
  output logic                   done_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [NBITS_COUNT-1:0] MAX_V  = NBITS_COUNT'(MAX_COUNT);
  localparam logic [NBITS_COUNT-1:0] ZERO_V = {NBITS_COUNT{1'b0}};
  localparam logic [NBITS_COUNT-1:0] ONE_V  = NBITS_COUNT'(1);
  localparam logic [PW-1:0]          PLAST  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NBITS_COUNT-1:0] count_q, count_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   dir_q, dir_d;
  logic                   ss_prev_q;
  logic                   ss_rise;
  logic                   tick;
  logic [NBITS_COUNT-1:0] next_cnt;
  logic [NBITS_COUNT-1:0] term_cnt;

  assign ss_rise  = start_stop_i & ~ss_prev_q;
  assign tick     = (presc_q == PLAST);
  assign next_cnt = dir_q ? (count_q - ONE_V) : (count_q + ONE_V);
  assign term_cnt = dir_q ? ZERO_V : MAX_V;

`ifdef LAP_EN
  logic                   hold_q, hold_d;
  logic [NBITS_COUNT-1:0] lapv_q, lapv_d;
  logic                   lap_prev_q;
  logic                   lap_rise;

  assign lap_rise = lap_i & ~lap_prev_q;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
`ifdef LAP_EN
    hold_d  = hold_q;
    lapv_d  = lapv_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
      count_d = ZERO_V;
      presc_d = '0;
`ifdef LAP_EN
      hold_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_rise) begin
            state_d = RUN;
            dir_d   = down_i;
            count_d = down_i ? MAX_V : ZERO_V;
            presc_d = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
            count_d = next_cnt;
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // Reaching the terminal value wins over a simultaneous pause request.
          if (tick && (next_cnt == term_cnt)) begin
            state_d = DONE;
          end else if (ss_rise) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (ss_rise) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (ss_rise) begin
            state_d = IDLE;
            count_d = ZERO_V;
            presc_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO_V;
          presc_d = '0;
        end
      endcase
`ifdef LAP_EN
      // Lap toggles only while staying in RUN/PAUSE; IDLE/DONE entry drops it.
      if ((state_d == IDLE) || (state_d == DONE)) begin
        hold_d = 1'b0;
      end else if (lap_rise && ((state_q == RUN) || (state_q == PAUSE))) begin
        hold_d = ~hold_q;
        if (!hold_q) begin
          lapv_d = count_q;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_2_i) begin
    ss_prev_q <= start_stop_i;
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= ZERO_V;
      presc_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
    end
  end

`ifdef LAP_EN
  always_ff @(posedge clk_2_i) begin
    lap_prev_q <= lap_i;
    if (reset_i) begin
      hold_q <= 1'b0;
      lapv_q <= ZERO_V;
    end else begin
      hold_q <= hold_d;
      lapv_q <= lapv_d;
    end
  end

  assign display_o = hold_q ? lapv_q : count_q;
`else
  assign display_o = count_q;
`endif

  assign count_o   = count_q;
  assign state_o   = state_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);

endmodule
